// File: rtl/imem_axil_sram_if.sv
// AXI4-Lite read-only channel bundle (AR + R) between the fetch stage and
// the instruction SRAM.
interface imem_axil_sram_if;
   logic        ARVALID;
   logic [31:0] ARADDR;
   logic        ARREADY;
   logic        RVALID;
   logic [63:0] RDATA;
   logic [1:0]  RRESP;
   logic        RREADY;

   modport master (output ARVALID, ARADDR, RREADY,
                   input  ARREADY, RVALID, RDATA, RRESP);
   modport slave  (input  ARVALID, ARADDR, RREADY,
                   output ARREADY, RVALID, RDATA, RRESP);
endinterface

// File: rtl/imem_axil_sram.sv
// Instruction SRAM behind an AXI4-Lite read port, one read in flight, fixed LATENCY.
// Define IMEM_RANGE_CHECK_EN to answer SLVERR for addresses outside the array.
module imem_axil_sram #(
   parameter int          DEPTH_LOG2 = 12,
   parameter int          LATENCY    = 2,
   parameter logic [31:0] BASE       = 32'h80000000
) (
   input  logic                  clk,
   input  logic                  rst,
   imem_axil_sram_if.slave       bus,
   input  logic                  ld_en,
   input  logic [DEPTH_LOG2-1:0] ld_addr,
   input  logic [63:0]           ld_data
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   logic [63:0]           r_mem [0:(1<<DEPTH_LOG2)-1];
   state_t                r_state, w_state_nxt;
   logic [3:0]            r_cnt, w_cnt_nxt;
   logic [63:0]           r_data;
   logic [1:0]            r_resp;
   logic                  w_ar_hs;
   logic [31:0]           w_off;
   logic [DEPTH_LOG2-1:0] w_idx;

   assign w_off = bus.ARADDR - BASE;
   assign w_idx = w_off[DEPTH_LOG2+2:3];

`ifdef IMEM_RANGE_CHECK_EN
   logic w_in_rng;
   logic w_unused;
   assign w_in_rng = (w_off[31:DEPTH_LOG2+3] == '0);
   assign w_unused = ^w_off[2:0];
`else
   logic w_unused;
   assign w_unused = ^{w_off[31:DEPTH_LOG2+3], w_off[2:0]};
`endif

   // Backdoor load port is deliberately outside reset so a held reset keeps the program.
   always_ff @(posedge clk) begin
      if (ld_en) r_mem[ld_addr] <= ld_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ar_hs     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.ARVALID) begin
               w_ar_hs = 1'b1;
               if (LATENCY == 1) begin
                  w_state_nxt = S_RESP;
               end else begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) w_state_nxt = S_RESP;
            else               w_cnt_nxt   = r_cnt - 4'd1;
         end
         S_RESP: begin
            if (bus.RREADY) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Word is snapshotted at the AR edge, so later ARADDR or ld_en activity cannot disturb it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data <= '0;
         r_resp <= 2'b00;
      end else if (w_ar_hs) begin
`ifdef IMEM_RANGE_CHECK_EN
         if (w_in_rng) begin
            r_data <= r_mem[w_idx];
            r_resp <= 2'b00;
         end else begin
            r_data <= '0;
            r_resp <= 2'b10;
         end
`else
         r_data <= r_mem[w_idx];
         r_resp <= 2'b00;
`endif
      end
   end

   assign bus.ARREADY = rst & (r_state == S_IDLE);
   assign bus.RVALID  = (r_state == S_RESP);
   assign bus.RDATA   = bus.RVALID ? r_data : 64'd0;
   assign bus.RRESP   = bus.RVALID ? r_resp : 2'b00;
endmodule
